// File: rtl/mult_seq_ctrl.sv
// Control sequencer for a shift-add unsigned multiplier datapath.
// It drives the clear/load/shift strobes for the product, multiplicand and Q
// registers, and steps through N multiplier bits. The adder and the registers
// themselves live outside this block.
module mult_seq_ctrl #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic q0,
    output logic busy,
    output logic done,
    output logic clrp,
    output logic ldm,
    output logic ldq,
    output logic ldp,
    output logic shp,
    output logic shq
);

    // Wide enough to hold N, the value count reaches on the final shift.
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_BIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_countNext;
    logic          w_last;

    assign w_last = (r_count == LAST);

    // State and bit-counter registers. Reset returns the sequencer to IDLE,
    // and the output decode then forces every strobe low.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_countNext;
        end
    end

    // Next-state and strobe decode. In BIT, the q0 input picks between an add
    // (ldp, followed by SHIFT) and a plain shift that stays in BIT.
    always_comb begin
        w_next      = r_state;
        w_countNext = r_count;
        busy        = 1'b0;
        done        = 1'b0;
        clrp        = 1'b0;
        ldm         = 1'b0;
        ldq         = 1'b0;
        ldp         = 1'b0;
        shp         = 1'b0;
        shq         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                busy        = 1'b1;
                clrp        = 1'b1;
                ldm         = 1'b1;
                ldq         = 1'b1;
                w_countNext = '0;
                w_next      = S_BIT;
            end
            S_BIT: begin
                busy = 1'b1;
                if (q0) begin
                    ldp    = 1'b1;
                    w_next = S_SHIFT;
                end else begin
                    shp         = 1'b1;
                    shq         = 1'b1;
                    w_countNext = r_count + 1'b1;
                    w_next      = w_last ? S_DONE : S_BIT;
                end
            end
            S_SHIFT: begin
                busy        = 1'b1;
                shp         = 1'b1;
                shq         = 1'b1;
                w_countNext = r_count + 1'b1;
                w_next      = w_last ? S_DONE : S_BIT;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
